num_entry_ctrl: RTL

Sequencing controller for the number-maker datapath (increment-by-decade / two's-complement negate unit). Converts operator push-button levels into single-cycle one-hot commands on the maker's switch inputs, holds the working number in a register, provides hold-to-auto-repeat, and hands the finished operand to the ALU through a valid/ready handshake. It sits between the board button inputs and the ALU operand-load port.

---
 rtl/num_entry_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/num_entry_ctrl.sv
// Button sequencer for the number-maker: one-cycle one-hot commands, hold-to-repeat,
// and a valid/ready hand-off of the working number to the ALU operand port.
module num_entry_ctrl #(
    parameter int unsigned BITS     = 16,
    parameter int unsigned DIGITS   = 6,
    parameter int unsigned HOLD_CYC = 500,
    parameter int unsigned REP_CYC  = 100
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DIGITS-2:0] BTN,
    input  logic              CLR,
    input  logic              LOAD,
    output logic [DIGITS-2:0] MK_SW,
    output logic [BITS-1:0]   MK_NUM,
    input  logic [BITS-1:0]   MK_OUT,
    output logic [BITS-1:0]   VAL,
    output logic              OP_VALID,
    output logic [BITS-1:0]   OP_DATA,
    input  logic              OP_READY,
    output logic              BUSY
);

    localparam int unsigned SW      = DIGITS - 1;
    localparam int unsigned NEG_BIT = DIGITS - 2;
    localparam int unsigned CNT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_HOLD,
        S_PRESENT
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_btn_q;
    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   r_mk_sw;
    logic [BITS-1:0] r_val;
    logic [CW-1:0]   r_cnt;
    logic            r_rep;
    logic            r_op_valid;
    logic            r_busy;

    logic [SW-1:0]   w_edge;
    logic [SW-1:0]   w_pick;
    logic            w_last;

    always_comb w_edge = BTN & ~r_btn_q;

    // Scan downward so the lowest set edge bit is the one left standing.
    always_comb begin
        w_pick = '0;
        for (int unsigned i = SW; i > 0; i--) begin
            if (w_edge[i-1]) begin
                w_pick      = '0;
                w_pick[i-1] = 1'b1;
            end
        end
    end

    always_comb w_last = (r_cnt == (r_rep ? REP_LAST : HOLD_LAST));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_btn_q    <= '0;
            r_sel      <= '0;
            r_mk_sw    <= '0;
            r_val      <= '0;
            r_cnt      <= '0;
            r_rep      <= 1'b0;
            r_op_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_btn_q <= BTN;
            case (r_state)
                S_IDLE: begin
                    if (CLR) begin
                        r_val <= '0;
                    end else if (LOAD) begin
                        r_op_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_PRESENT;
                    end else if (w_edge != '0) begin
                        r_sel   <= w_pick;
                        r_mk_sw <= w_pick;
                        r_rep   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_val   <= MK_OUT;
                    r_cnt   <= '0;
                    r_mk_sw <= '0;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (CLR) begin
                        r_val   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if ((BTN & r_sel) == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!r_sel[NEG_BIT]) begin
                        // Command is raised together with the STEP entry so MK_SW is registered.
                        if (w_last) begin
                            r_rep   <= 1'b1;
                            r_mk_sw <= r_sel;
                            r_state <= S_STEP;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_PRESENT: begin
                    if (OP_READY) begin
                        r_op_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign MK_SW    = r_mk_sw;
    assign MK_NUM   = r_val;
    assign VAL      = r_val;
    assign OP_VALID = r_op_valid;
    assign OP_DATA  = r_val;
    assign BUSY     = r_busy;

endmodule
